// File: rtl/mpu_load_multi_if.sv
// Handshake and register-file write bus between the sequencer/source and mpu_load_multi.
// The master side drives requests and beats; the slave side is the loader.
interface mpu_load_multi_if #(
  parameter int unsigned FP              = 32,
  parameter int unsigned M               = 4,
  parameter int unsigned N               = 4,
  parameter int unsigned LANES           = 2,
  parameter int unsigned MATRIX_REG_SIZE = 2
);
  localparam int unsigned MBITS = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned NBITS = (N > 1) ? $clog2(N) : 1;

  logic                       start;
  logic                       transpose;
  logic [MBITS:0]             matrix_m_size;
  logic [NBITS:0]             matrix_n_size;
  logic [MATRIX_REG_SIZE-1:0] load_addr;
  logic                       in_valid;
  logic [LANES*FP-1:0]        in_data;
  logic                       in_ready;
  logic                       busy;
  logic                       ack;
  logic                       error;
  logic                       write_en;
  logic [MATRIX_REG_SIZE-1:0] reg_load_addr;
  logic [FP-1:0]              element_out;
  logic [MBITS-1:0]           m;
  logic [NBITS-1:0]           n;

  modport master (
    output start, transpose, matrix_m_size, matrix_n_size, load_addr, in_valid, in_data,
    input  in_ready, busy, ack, error, write_en, reg_load_addr, element_out, m, n
  );

  modport slave (
    input  start, transpose, matrix_m_size, matrix_n_size, load_addr, in_valid, in_data,
    output in_ready, busy, ack, error, write_en, reg_load_addr, element_out, m, n
  );
endinterface

// File: rtl/mpu_load_multi.sv
// Matrix loader: accepts LANES-element beats and serialises them into one register-file
// element write per cycle, with size validation, partial final beats and transpose-on-load.
module mpu_load_multi #(
  parameter int unsigned FP              = 32,
  parameter int unsigned M               = 4,
  parameter int unsigned N               = 4,
  parameter int unsigned LANES           = 2,
  parameter int unsigned MATRIX_REG_SIZE = 2
) (
  input  logic               clk,
  input  logic               rst,
  mpu_load_multi_if.slave    bus
);
  localparam int unsigned MBITS = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned NBITS = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCEPT,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t                          state_q, state_d;
  logic [MBITS:0]                  ms_q, ms_d;
  logic [NBITS:0]                  ns_q, ns_d;
  logic                            tr_q, tr_d;
  logic [MATRIX_REG_SIZE-1:0]      addr_q, addr_d;
  logic [LANES-1:0][FP-1:0]        lane_buf_q, lane_buf_d;
  logic [LW-1:0]                   lane_q, lane_d;
  logic [MBITS-1:0]                i_q, i_d;
  logic [NBITS-1:0]                j_q, j_d;

  logic                            in_ready_q, busy_q, ack_q, error_q, write_en_q;
  logic [MATRIX_REG_SIZE-1:0]      reg_load_addr_q;
  logic [FP-1:0]                   element_q;
  logic [MBITS-1:0]                m_q;
  logic [NBITS-1:0]                n_q;

  logic                            size_ok_c;
  logic                            last_c;
  logic                            j_end_c;

  // Request validation on the raw inputs; transposed loads must also fit the swapped shape.
  always_comb begin
    size_ok_c = (bus.matrix_m_size != '0) && (32'(bus.matrix_m_size) <= M) &&
                (bus.matrix_n_size != '0) && (32'(bus.matrix_n_size) <= N) &&
                (!bus.transpose ||
                 ((32'(bus.matrix_n_size) <= M) && (32'(bus.matrix_m_size) <= N)));
  end

  // (i_q, j_q) is the source position of the element being written in the current DRAIN cycle.
  always_comb begin
    j_end_c = ((NBITS+1)'(j_q) == (ns_q - (NBITS+1)'(1)));
    last_c  = j_end_c && ((MBITS+1)'(i_q) == (ms_q - (MBITS+1)'(1)));
  end

  always_comb begin
    state_d    = state_q;
    ms_d       = ms_q;
    ns_d       = ns_q;
    tr_d       = tr_q;
    addr_d     = addr_q;
    lane_buf_d = lane_buf_q;
    lane_d     = lane_q;
    i_d        = i_q;
    j_d        = j_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          ms_d    = bus.matrix_m_size;
          ns_d    = bus.matrix_n_size;
          tr_d    = bus.transpose;
          addr_d  = bus.load_addr;
          i_d     = '0;
          j_d     = '0;
          lane_d  = '0;
          state_d = size_ok_c ? S_ACCEPT : S_ERR;
        end
      end
      S_ACCEPT: begin
        if (bus.in_valid) begin
          lane_buf_d = bus.in_data;
          lane_d     = '0;
          state_d    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Final element ends the load even mid-beat; leftover lanes are dropped.
        if (last_c) begin
          state_d = S_DONE;
        end else begin
          if (j_end_c) begin
            j_d = '0;
            i_d = i_q + MBITS'(1);
          end else begin
            j_d = j_q + NBITS'(1);
          end
          if (lane_q == LW'(LANES-1)) state_d = S_ACCEPT;
          else                        lane_d  = lane_q + LW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and outputs registered from the next-state values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      ms_q            <= '0;
      ns_q            <= '0;
      tr_q            <= 1'b0;
      addr_q          <= '0;
      lane_buf_q      <= '0;
      lane_q          <= '0;
      i_q             <= '0;
      j_q             <= '0;
      in_ready_q      <= 1'b0;
      busy_q          <= 1'b0;
      ack_q           <= 1'b0;
      error_q         <= 1'b0;
      write_en_q      <= 1'b0;
      reg_load_addr_q <= '0;
      element_q       <= '0;
      m_q             <= '0;
      n_q             <= '0;
    end else begin
      state_q         <= state_d;
      ms_q            <= ms_d;
      ns_q            <= ns_d;
      tr_q            <= tr_d;
      addr_q          <= addr_d;
      lane_buf_q      <= lane_buf_d;
      lane_q          <= lane_d;
      i_q             <= i_d;
      j_q             <= j_d;
      in_ready_q      <= (state_d == S_ACCEPT);
      busy_q          <= (state_d != S_IDLE);
      ack_q           <= (state_d == S_DONE);
      error_q         <= (state_d == S_ERR);
      write_en_q      <= (state_d == S_DRAIN);
      reg_load_addr_q <= addr_d;
      if (state_d == S_DRAIN) begin
        element_q <= lane_buf_d[lane_d];
        m_q       <= tr_d ? MBITS'(j_d) : i_d;
        n_q       <= tr_d ? NBITS'(i_d) : j_d;
      end
    end
  end

  assign bus.in_ready      = in_ready_q;
  assign bus.busy          = busy_q;
  assign bus.ack           = ack_q;
  assign bus.error         = error_q;
  assign bus.write_en      = write_en_q;
  assign bus.reg_load_addr = reg_load_addr_q;
  assign bus.element_out   = element_q;
  assign bus.m             = m_q;
  assign bus.n             = n_q;
endmodule

// File: doc/mpu_load_multi.md
Name: mpu_load_multi

Overview:
Parametrised successor to mpu_load: accepts a matrix as a stream of multi-element beats (LANES elements per beat) under a valid/ready handshake. It buffers each beat and serialises it into the one-element-per-cycle write port of mpu_register_file. Adds size validation against M/N, partial final beats, an optional transpose-on-load mode, and a busy indication. It sits between the memory/file source and mpu_register_file, under control of the MPU sequencer.

Parameters:
FP, 32, element width in bits (IEEE-754 single).
M, 4, maximum matrix rows.
N, 4, maximum matrix columns.
LANES, 2, elements per input beat, 1..M*N.
MATRIX_REG_SIZE, 2, register-file address width.
MBITS, $clog2(M), row index width (derived).
NBITS, $clog2(N), column index width (derived).

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a load; sampled only in IDLE.
transpose  in  1  sampled with start; 1 = store element (i,j) at (j,i).
matrix_m_size  in  MBITS+1  source rows, sampled with start.
matrix_n_size  in  NBITS+1  source columns, sampled with start.
load_addr  in  MATRIX_REG_SIZE  destination register, sampled with start.
in_valid  in  1  beat valid.
in_data  in  LANES*FP  beat; lane 0 = bits [FP-1:0] = earliest element in row-major order.
in_ready  out  1  block can accept a beat.
busy  out  1  high from start acceptance until the ack/error cycle inclusive.
ack  out  1  one-cycle pulse after the final element write.
error  out  1  one-cycle pulse on size rejection.
write_en  out  1  register-file element write strobe.
reg_load_addr  out  MATRIX_REG_SIZE  destination register.
element_out  out  FP  element being written.
m  out  MBITS  destination row index.
n  out  NBITS  destination column index.

Behaviour:
- Reset (rst low, async): state IDLE. in_ready, busy, ack, error, write_en = 0. element_out, m, n, reg_load_addr = 0. Lane buffer and counters cleared. Reset mid-load aborts the load with no ack; writes already issued are not undone.
- States: IDLE, ACCEPT, DRAIN, DONE, ERR.
- IDLE:
  - On start, latch sizes, transpose and load_addr.
  - If 1<=m_size<=M and 1<=n_size<=N, go to ACCEPT. If transpose=1, additionally require n_size<=M and m_size<=N; otherwise the request is invalid.
  - If invalid, go to ERR.
  - start outside IDLE is ignored.
- ERR: error=1 for exactly one cycle, busy=1, no writes; then IDLE.
- ACCEPT: in_ready=1. On in_valid&&in_ready, capture in_data into the lane buffer and go to DRAIN. in_valid low holds ACCEPT indefinitely (no timeout). in_ready=0 in all other states.
- DRAIN:
  - write_en=1 for one cycle per lane, lane 0 first, with element_out registered from the buffer.
  - Counter k runs 0..m_size*n_size-1. Source position i=k/n_size, j=k%n_size, tracked with wrap counters; no divider.
  - transpose=0 drives m=i, n=j. transpose=1 drives m=j, n=i.
  - reg_load_addr = latched load_addr throughout.
  - After the last lane of a beat, go to ACCEPT if elements remain.
  - After the final element, go to DONE immediately, even mid-beat. Unused lanes of the final partial beat are discarded and never written.
- DONE: ack=1 for one cycle, busy=1; then IDLE. The next start is accepted the cycle after.
- Throughput: a full beat costs 1 accept cycle + LANES write cycles. Total load latency from start (with in_valid held high) = 1 + ceil(mn/LANES) + mn cycles to the ack cycle.
- Element writes happen at most once per (m,n) position per load. Positions outside the loaded m_size x n_size region of the register are untouched.
- Outputs m, n and element_out hold their last values when write_en=0.

Test Plan:
1. LANES=2, 2x2, beats {1.0, 50.33}, {-2.5, 0.125}, in_valid always high -> four writes at (0,0),(0,1),(1,0),(1,1) with exactly those values; ack one cycle after the 4th write; matrix_out[1][0]=0xc0200000.
2. 3x3 with LANES=2 -> 5 beats accepted; the last beat lane 1 is never written; exactly 9 write_en cycles, then ack.
3. transpose=1, 2x3, elements 1..6 -> element 2.0 written at (1,0) and 4.0 at (0,1); ack asserted.
4. m_size=0, then m_size=M+1, then transpose with n_size>M -> error pulse each time, busy for 1 cycle, zero write_en, in_ready never asserted.
5. Backpressure: in_valid toggles 1,0,0,1 -> in_ready stays high while waiting; no duplicate or dropped elements; write order unchanged.
6. rst low during DRAIN of the second beat of a 2x2 load -> all outputs 0 immediately, no ack; a fresh start after release completes normally.
